// File: rtl/onehot_seq_gen_if.sv
// Control/status bundle between a sequencer and the block that drives it.
// The master side issues start/stop/hold/abort and the dwell table. The slave side reports the one-hot stage.
`timescale 1ns/1ps
interface onehot_seq_gen_if #(
    parameter int NUM_STATES = 4,
    parameter int DWELL_W    = 8,
    parameter int IDX_W      = $clog2(NUM_STATES)
);
    logic                          start;
    logic                          mode;
    logic                          stop;
    logic                          hold;
    logic                          abort;
    logic [NUM_STATES*DWELL_W-1:0] dwell_cfg;
    logic [NUM_STATES-1:0]         state_oh;
    logic [IDX_W-1:0]              stage_idx;
    logic                          busy;
    logic                          done;
    logic                          err;

    modport master (
        output start, mode, stop, hold, abort, dwell_cfg,
        input  state_oh, stage_idx, busy, done, err
    );

    modport slave (
        input  start, mode, stop, hold, abort, dwell_cfg,
        output state_oh, stage_idx, busy, done, err
    );
endinterface

// File: rtl/onehot_seq_gen.sv
// One-hot stage sequencer. Each stage has a programmable dwell and loop/single-shot mode.
// It supports hold, abort, graceful stop and recovery from corrupted state encodings.
`timescale 1ns/1ps
module onehot_seq_gen #(
    parameter int NUM_STATES = 4,
    parameter int DWELL_W    = 8,
    parameter int IDX_W      = $clog2(NUM_STATES)
) (
    input  logic               clk,
    input  logic               reset,
    onehot_seq_gen_if.slave    bus
);
    localparam int CFG_W = NUM_STATES * DWELL_W;
    localparam logic [NUM_STATES-1:0] IDLE_OH  = NUM_STATES'(1);
    localparam logic [NUM_STATES-1:0] FIRST_OH = NUM_STATES'(2);

    logic [NUM_STATES-1:0] state_oh_q, state_oh_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic                  mode_q, mode_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [IDX_W-1:0]      idx;
    logic                  in_idle;
    logic                  legal;
    logic                  stop_now;

    function automatic logic [DWELL_W-1:0] dwell_of(input logic [CFG_W-1:0] cfg, input int k);
        return cfg[k*DWELL_W +: DWELL_W];
    endfunction

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (state_oh_q[i]) idx = IDX_W'(i);
        end
    end

    assign in_idle  = (state_oh_q == IDLE_OH);
    assign legal    = $onehot(state_oh_q);
    // A stop seen in the very cycle the last stage expires still ends the loop.
    assign stop_now = stop_pend_q | (bus.stop & mode_q);

    always_comb begin
        state_oh_d  = state_oh_q;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (bus.abort && !in_idle) begin
            state_oh_d  = IDLE_OH;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
        end else if (!legal) begin
            state_oh_d  = IDLE_OH;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
            err_d       = 1'b1;
        end else if (!bus.hold) begin
            if (in_idle) begin
                if (bus.start && !bus.abort) begin
                    cfg_d      = bus.dwell_cfg;
                    mode_d     = bus.mode;
                    state_oh_d = FIRST_OH;
                    cnt_d      = dwell_of(bus.dwell_cfg, 1);
                end
            end else begin
                stop_pend_d = stop_now;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (state_oh_q[NUM_STATES-1]) begin
                    done_d = 1'b1;
                    if (mode_q && !stop_now) begin
                        state_oh_d = FIRST_OH;
                        cnt_d      = dwell_of(cfg_q, 1);
                    end else begin
                        state_oh_d  = IDLE_OH;
                        cnt_d       = '0;
                        stop_pend_d = 1'b0;
                    end
                end else begin
                    state_oh_d = state_oh_q << 1;
                    cnt_d      = dwell_of(cfg_q, int'(idx) + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_oh_q  <= IDLE_OH;
            cnt_q       <= '0;
            cfg_q       <= '0;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_oh_q  <= state_oh_d;
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.state_oh  = state_oh_q;
    assign bus.stage_idx = idx;
    assign bus.busy      = !in_idle;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_onehot_seq_gen.sv
// Bench for onehot_seq_gen: a legacy 3-state instance, directed scenarios on a 4-state instance,
// then random control traffic compared against a stage/elapsed-cycle reference model.
`timescale 1ns/1ps
module tb_onehot_seq_gen;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    onehot_seq_gen_if #(.NUM_STATES(N), .DWELL_W(DW), .IDX_W(IW)) bus ();
    onehot_seq_gen #(.NUM_STATES(N), .DWELL_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));

    onehot_seq_gen_if #(.NUM_STATES(3), .DWELL_W(DW), .IDX_W(2)) bus3 ();
    onehot_seq_gen #(.NUM_STATES(3), .DWELL_W(DW), .IDX_W(2)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.mode = 0; bus.stop = 0; bus.hold = 0; bus.abort = 0; bus.dwell_cfg = '0;
        bus3.start = 0; bus3.mode = 0; bus3.stop = 0; bus3.hold = 0; bus3.abort = 0; bus3.dwell_cfg = '0;
    endtask

    // Reference model: integer stage number plus cycles already spent in the stage.
    int m_stage, m_elapsed, m_loop, m_stop;
    int m_dwell[N];
    bit m_done;

    task automatic model_step();
        m_done = 0;
        if (bus.abort && m_stage != 0) begin
            m_stage = 0; m_elapsed = 0; m_stop = 0;
        end else if (!bus.hold) begin
            if (m_stage == 0) begin
                if (bus.start && !bus.abort) begin
                    for (int k = 0; k < N; k++) m_dwell[k] = int'(bus.dwell_cfg[k*DW +: DW]);
                    m_loop = int'(bus.mode); m_stage = 1; m_elapsed = 0;
                end
            end else begin
                if (bus.stop && m_loop != 0) m_stop = 1;
                m_elapsed++;
                if (m_elapsed > m_dwell[m_stage]) begin
                    m_elapsed = 0;
                    if (m_stage == N-1) begin
                        m_done = 1;
                        if (m_loop != 0 && m_stop == 0) m_stage = 1;
                        else begin m_stage = 0; m_stop = 0; end
                    end else begin
                        m_stage++;
                    end
                end
            end
        end
    endtask

    int exp_idx2[7]  = '{1, 1, 1, 2, 3, 3, 0};
    int exp_oh3[7]   = '{2, 4, 8, 2, 4, 8, 1};
    int exp_dn3[7]   = '{0, 0, 0, 1, 0, 0, 1};
    int exp_oh1[3]   = '{2, 4, 1};

    initial begin
        int n, busy_cnt;
        logic [N-1:0] e_oh;

        idle_inputs();
        reset = 1'b1;
        #12;
        chk("rst_state", bus.state_oh, 1);
        chk("rst_idx", bus.stage_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Legacy 3-state behaviour
        bus3.start = 1;
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus3.start = 0;
            chk("t1_state", bus3.state_oh, exp_oh1[i]);
            chk("t1_done", bus3.done, (i == 2));
            if (bus3.busy) busy_cnt++;
        end
        chk("t1_busy_cycles", busy_cnt, 2);

        // Per-stage dwell, single shot
        bus.dwell_cfg = {8'd1, 8'd0, 8'd2, 8'd0};
        bus.mode = 0; bus.start = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.start = 0;
            chk("t2_idx", bus.stage_idx, exp_idx2[i]);
            chk("t2_done", bus.done, (i == 6));
        end

        // Loop mode with stop during the second pass
        bus.dwell_cfg = '0; bus.mode = 1; bus.start = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.start = 0;
            bus.stop = (i == 3);
            chk("t3_state", bus.state_oh, exp_oh3[i]);
            chk("t3_done", bus.done, exp_dn3[i]);
            chk("t3_busy", bus.busy, (exp_oh3[i] != 1));
        end
        bus.stop = 0;

        // Hold inside stage 1
        bus.dwell_cfg = {8'd0, 8'd0, 8'd3, 8'd0}; bus.mode = 0; bus.start = 1;
        tick();
        bus.start = 0;
        n = 1;
        for (int j = 0; j < 30; j++) begin
            bus.hold = (j >= 1 && j <= 5);
            tick();
            if (bus.hold) begin
                chk("t4_hold_done", bus.done, 0);
                chk("t4_hold_err", bus.err, 0);
            end
            if (bus.state_oh == 4'b0010) n++;
            else break;
        end
        bus.hold = 0;
        chk("t4_stage1_len", n, 9);
        for (int j = 0; j < 10 && bus.state_oh != 4'b0001; j++) tick();
        chk("t4_idle", bus.state_oh, 1);

        // Abort beats hold; abort+start in IDLE stays IDLE
        bus.dwell_cfg = {8'd0, 8'd5, 8'd0, 8'd0}; bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        chk("t5_stage2", bus.state_oh, 4'b0100);
        bus.hold = 1; bus.abort = 1;
        tick();
        chk("t5_abort_state", bus.state_oh, 1);
        chk("t5_abort_done", bus.done, 0);
        chk("t5_abort_busy", bus.busy, 0);
        bus.hold = 0; bus.start = 1;
        tick();
        chk("t5_start_abort", bus.state_oh, 1);
        bus.start = 0; bus.abort = 0;
        tick();
        chk("t5_still_idle", bus.state_oh, 1);

        // Illegal encoding recovery
        bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        force dut.state_oh_q = 4'b0110;
        #1;
        release dut.state_oh_q;
        tick();
        chk("t6_recover_state", bus.state_oh, 1);
        chk("t6_err_pulse", bus.err, 1);
        tick();
        chk("t6_err_clear", bus.err, 0);

        // Asynchronous reset mid-stage
        bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        chk("t6_pre_reset", bus.state_oh, 4'b0100);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_state", bus.state_oh, 1);
        chk("t6_rst_idx", bus.stage_idx, 0);
        chk("t6_rst_flags", {bus.busy, bus.done, bus.err}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the reference model
        m_stage = 0; m_elapsed = 0; m_loop = 0; m_stop = 0; m_done = 0;
        for (int k = 0; k < N; k++) m_dwell[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.start = ($urandom % 4) == 0;
            bus.mode  = 1'($urandom % 2);
            bus.stop  = ($urandom % 16) == 0;
            bus.hold  = ($urandom % 8) == 0;
            bus.abort = ($urandom % 40) == 0;
            for (int k = 0; k < N; k++) bus.dwell_cfg[k*DW +: DW] = DW'($urandom_range(0, 3));
            @(posedge clk);
            model_step();
            #1;
            e_oh = N'(1) << m_stage;
            chk("rnd_state", bus.state_oh, e_oh);
            chk("rnd_idx", bus.stage_idx, m_stage);
            chk("rnd_flags", {bus.busy, bus.done, bus.err}, {(m_stage != 0), m_done, 1'b0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/onehot_seq_gen.md
Name: onehot_seq_gen

Overview:
Parametrised one-hot stage sequencer; next generation of the fixed 3-state start-triggered sequencer.
- Walks NUM_STATES one-hot stages; bit0 is IDLE.
- Adds per-stage programmable dwell, single-shot/loop mode, hold, abort, graceful stop, completion pulse and illegal-encoding recovery.
- Drives stage-enable strobes of downstream datapath blocks.

Parameters:
NUM_STATES, 4, total one-hot states including IDLE (bit0); legal range 2..16
DWELL_W, 8, width of each per-stage dwell count
IDX_W, $clog2(NUM_STATES), width of stage_idx

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  begin a sequence; sampled only in IDLE
mode  in  1  0 = single-shot, 1 = loop; sampled with start
stop  in  1  loop mode: finish current pass, then go to IDLE
hold  in  1  freeze state and dwell counter while high
abort  in  1  return to IDLE next cycle, no done
dwell_cfg  in  NUM_STATES*DWELL_W  dwell of stage k at bits [k*DWELL_W +: DWELL_W]; slice 0 unused; captured at start
state_oh  out  NUM_STATES  registered one-hot state
stage_idx  out  IDX_W  binary index of set bit in state_oh
busy  out  1  high whenever state_oh != IDLE
done  out  1  1-cycle pulse on completion of last stage
err  out  1  1-cycle pulse when illegal encoding detected

Behaviour:
- Reset (async): state_oh = 1 (IDLE), stage_idx = 0, busy = 0, done = 0, err = 0, dwell counter = 0, latched config = 0, stop_pend = 0.
- Dwell: stage k (k>=1) occupies exactly dwell_k + 1 cycles, excluding hold cycles. Dwell 0 gives 1 cycle/stage, the legacy behaviour.
- Counter: loaded with latched dwell_k on stage entry; decrements each non-hold cycle; stage advances when counter == 0.
- IDLE + start (abort low): latch dwell_cfg and mode; next cycle state_oh = 1<<1, busy = 1.
- start while busy: ignored. Config changes while busy: ignored until next start.
- Advance: stage k -> k+1 for k < NUM_STATES-1.
- Last stage expiry:
  - single mode -> IDLE.
  - loop mode -> stage 1 (IDLE skipped), unless stop_pend -> IDLE.
  - done = 1 in the cycle after last-stage expiry, in both modes.
- stop: sets stop_pend when asserted while busy in loop mode; cleared on entry to IDLE. Ignored in single mode.
- Priority, highest first: abort > illegal-encoding recovery > hold > normal advance.
  - abort while busy: next cycle IDLE; done = 0; counter and stop_pend cleared.
  - abort in IDLE: no effect; abort+start simultaneously in IDLE stays IDLE.
  - hold: state, counter, stop_pend frozen; done/err cannot fire; abort still acts.
- Illegal state_oh (zero or >1 bits set): next cycle IDLE; err = 1 for one cycle; counter cleared.
- Outputs: stage_idx and busy are combinational decodes of registered state_oh; done and err are registered.
- NUM_STATES = 3, dwell all 0, mode 0: cycle-identical to the legacy 3-state sequencer.

Test Plan:
1. NUM_STATES=3, dwell 0, mode 0, 1-cycle start -> state_oh 001,010,100,001 on successive cycles; done high the cycle 001 returns; busy high 2 cycles.
2. NUM_STATES=4, dwell {-,2,0,1}, mode 0 -> stage1 3 cycles, stage2 1 cycle, stage3 2 cycles, then IDLE; done once; stage_idx 1,1,1,2,3,3,0.
3. Loop mode, dwell all 0, NUM_STATES=4; stop pulsed during 2nd pass -> sequence 2,4,8,2,4,8,1; done pulses twice; busy drops on IDLE.
4. hold high 5 cycles mid stage1 (dwell 3) -> stage1 occupies 4 active + 5 held = 9 cycles; no done/err during hold.
5. abort in stage2 with hold also high -> IDLE next cycle, done stays 0; start same cycle as abort in IDLE -> remains IDLE.
6. Force state_oh = 0110 via bench backdoor -> next cycle state_oh = 0001, err pulse 1 cycle; assert reset mid-stage -> immediate 0001, all outputs 0.
